rs_encoder_serial: RTL
======================

// Module: rs_encoder_serial
// PURPOSE
//  Systematic RS(7,5) encoder over GF(2^3), primitive polynomial x^3+x+1, alpha=3'b010.
//  Generator g(x)=(x-a)(x-a^2)=x^2+a^4*x+a^3, so g1=3'd6 and g0=3'd3.
//  Accepts K message symbols, one per handshake, highest degree first.
//  Emits an N-symbol codeword word that is bit-compatible with RS_Decoder's `codeword` input.
//  Is the transmit-side source for the decoder path, in benches and in loopback tops.
// PARAMETERS
//  SYMBOL_WIDTH  3  bits per symbol; the GF tables are fixed for 3, other values are illegal.
//  N             7  codeword length in symbols.
//  K             5  message length in symbols; N-K=2 parity symbols.
// PORTS
//  clk        in   1        rising-edge clock, the single clock domain.
//  reset      in   1        asynchronous, active-high; clears all state.
//  msg_valid  in   1        msg_sym is valid this cycle.
//  msg_ready  out  1        encoder can accept a symbol.
//  msg_sym    in   SW       message symbol; the first one accepted is c[N-1].
//  cw_valid   out  1        codeword is valid and held stable.
//  cw_ready   in   1        consumer takes the codeword.
//  codeword   out  N*SW     {c6,c5,...,c0}: c6 in bits [20:18], parity c1,c0 in [5:0].
// BEHAVIOUR
//  Reset state: state=COLLECT, cnt=0, r1=r0=0, msg_ready=1, cw_valid=0, codeword=0.
//  Handshakes:
//   - A message transfer occurs when msg_valid&&msg_ready on a clk edge.
//   - A codeword transfer occurs when cw_valid&&cw_ready.
//  COLLECT state: msg_ready=1, cw_valid=0.
//   - Each transfer shifts msg_sym into message buffer slot c[N-1-cnt] and increments cnt.
//   - Each transfer also clocks the parity LFSR:
//     fb=msg_sym^r1; r1<=r0^gmul(fb,g1); r0<=gmul(fb,g0).
//   - gmul is GF(8) multiply with reduction x^3=x+1; it is purely combinational.
//   - On the K-th transfer (cnt==K-1): go to EMIT.
//     The same edge loads codeword={buffer,msg_sym,r1_next,r0_next}, cnt<=0.
//  EMIT state: msg_ready=0, cw_valid=1.
//   - codeword is held constant until the transfer.
//   - On cw_ready: go to COLLECT and clear r1,r0.
//   - codeword keeps its last value; consumers use only cw_valid.
//  Latency: cw_valid rises the cycle after the K-th message transfer.
//   - Zero added stall: with msg_valid held high, K accept cycles are followed by >=1 EMIT cycle.
//  Throughput: one codeword per K+1 cycles when cw_ready is held high.
//  msg_valid while msg_ready=0 is ignored; msg_sym is not sampled.
//  cw_ready while cw_valid=0 has no effect.
//  Gaps: msg_valid may drop mid-message; partial state (cnt, buffer, r1, r0) is retained indefinitely.
//  Reset asserted mid-message or mid-EMIT: immediate return to the reset state; the partial message is discarded.
//  Arithmetic: all symbol math is XOR/GF(8); no carries.
//   - cnt is ceil(log2(K)) bits and never exceeds K-1.
// STRUCTURE
//  rs_pkg (shared with RS_Decoder) holds:
//   - localparams SYMBOL_WIDTH, N, K, PRIM_POLY=4'b1011, G1=3'd6, G0=3'd3.
//   - typedef sym_t.
//   - function gf_mul(sym_t a, sym_t b).
//   - enum enc_state_t {COLLECT, EMIT}.
//  Sub-module rs_parity_lfsr holds:
//   - ports clk, reset, clr, shift, sym_in; outputs r1, r0, r1_next, r0_next.
//   - the two GF constant multipliers.
//  The top keeps the FSM, counter, message buffer and codeword register.
// TESTING
//  1. Reset released, no msg_valid: msg_ready=1, cw_valid=0, codeword=0 for 10 cycles.
//  2. Back-to-back msg [0,1,6,3,1], cw_ready=1:
//     - cw_valid rises exactly 1 cycle after the 5th transfer.
//     - codeword={0,1,6,3,1,6,3}=21'b000_001_110_011_001_110_011.
//  3. msg [1,0,0,0,0] -> codeword {1,0,0,0,0,6,2}.
//     - Feed it to RS_Decoder: corrected equals the input, i.e. zero syndromes.
//  4. Gaps and backpressure:
//     - msg_valid toggles 1/0 with random gaps; result still {0,1,6,3,1,6,3}.
//     - cw_ready held low 8 cycles: cw_valid and codeword remain stable, msg_ready=0.
//     - msg_valid pulses during the stall are ignored.
//  5. Async reset asserted after 3 transfers (between edges):
//     - outputs clear immediately.
//     - then a fresh [1,0,0,0,0] yields {1,0,0,0,0,6,2}, with no residue from before.
//  6. Two messages streamed with cw_ready=1:
//     - second codeword is correct, i.e. the LFSR was cleared.
//     - msg_ready is low exactly one cycle between messages.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared RS(7,5) over GF(2^3) definitions: field constants, symbol type,
// GF multiply and the encoder state type.
package rs_pkg;

   localparam int SYMBOL_WIDTH = 3;
   localparam int N            = 7;
   localparam int K            = 5;
   localparam int CNT_W        = $clog2(K);

   localparam logic [SYMBOL_WIDTH:0] PRIM_POLY = 4'b1011;

   typedef logic [SYMBOL_WIDTH-1:0] sym_t;

   localparam sym_t G1 = 3'd6;
   localparam sym_t G0 = 3'd3;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } enc_state_t;

   // Carry-less product followed by reduction modulo x^3+x+1, top bit first.
   function automatic sym_t gf_mul(sym_t a, sym_t b);
      logic [2*SYMBOL_WIDTH-2:0] p;
      p = '0;
      for (int i = 0; i < SYMBOL_WIDTH; i++) begin
         if (b[i]) begin
            p = p ^ ({{(SYMBOL_WIDTH-1){1'b0}}, a} << i);
         end
      end
      for (int i = 2*SYMBOL_WIDTH-2; i >= SYMBOL_WIDTH; i--) begin
         if (p[i]) begin
            p = p ^ ({{(SYMBOL_WIDTH-2){1'b0}}, PRIM_POLY} << (i - SYMBOL_WIDTH));
         end
      end
      return p[SYMBOL_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/rs_parity_lfsr.sv
// Two-stage parity LFSR dividing by g(x)=x^2+G1*x+G0; exposes both the
// current remainder and the value it will take on the next shift.
module rs_parity_lfsr
   import rs_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    shift,
   input  logic [SYMBOL_WIDTH-1:0] sym_in,
   output logic [SYMBOL_WIDTH-1:0] r1,
   output logic [SYMBOL_WIDTH-1:0] r0,
   output logic [SYMBOL_WIDTH-1:0] r1_next,
   output logic [SYMBOL_WIDTH-1:0] r0_next
);

   sym_t r1_q;
   sym_t r0_q;
   sym_t fb;

   assign fb      = sym_in ^ r1_q;
   assign r1_next = r0_q ^ gf_mul(fb, G1);
   assign r0_next = gf_mul(fb, G0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r1_q <= '0;
         r0_q <= '0;
      end else if (clr) begin
         r1_q <= '0;
         r0_q <= '0;
      end else if (shift) begin
         r1_q <= r1_next;
         r0_q <= r0_next;
      end
   end

   assign r1 = r1_q;
   assign r0 = r0_q;

endmodule

// File: rtl/rs_encoder_serial.sv
// Systematic RS(7,5) encoder: collects K symbols over a valid/ready link and
// presents the full codeword {c6..c0} on a second valid/ready link.
module rs_encoder_serial
   import rs_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      msg_valid,
   output logic                      msg_ready,
   input  logic [SYMBOL_WIDTH-1:0]   msg_sym,
   output logic                      cw_valid,
   input  logic                      cw_ready,
   output logic [N*SYMBOL_WIDTH-1:0] codeword
);

   enc_state_t                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [N*SYMBOL_WIDTH-1:0] cw_q, cw_d, cw_load;
   sym_t                      msg_buf_q [K-1];
   logic                      msg_xfer;
   logic                      lfsr_clr;
   sym_t                      r1_cur, r0_cur, r1_next, r0_next;
   logic                      lfsr_state_unused;

   assign msg_xfer = msg_valid && msg_ready;

   rs_parity_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .clr     (lfsr_clr),
      .shift   (msg_xfer),
      .sym_in  (msg_sym),
      .r1      (r1_cur),
      .r0      (r0_cur),
      .r1_next (r1_next),
      .r0_next (r0_next)
   );

   // The registered remainder is only observed through r*_next at load time.
   assign lfsr_state_unused = ^{r1_cur, r0_cur};

   // Buffer slot gi holds c[N-1-gi]; the final symbol and parity bypass it.
   genvar gi;
   generate
      for (gi = 0; gi < K-1; gi++) begin : g_pack
         assign cw_load[(N-1-gi)*SYMBOL_WIDTH +: SYMBOL_WIDTH] = msg_buf_q[gi];
      end
   endgenerate

   assign cw_load[(N-K)*SYMBOL_WIDTH +: SYMBOL_WIDTH] = msg_sym;
   assign cw_load[SYMBOL_WIDTH +: SYMBOL_WIDTH]       = r1_next;
   assign cw_load[0 +: SYMBOL_WIDTH]                  = r0_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < K-1; i++) begin
            msg_buf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < K-1; i++) begin
            if (msg_xfer && cnt_q == CNT_W'(i)) begin
               msg_buf_q[i] <= msg_sym;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cw_d      = cw_q;
      msg_ready = 1'b0;
      cw_valid  = 1'b0;
      lfsr_clr  = 1'b0;
      case (state_q)
         COLLECT: begin
            msg_ready = 1'b1;
            if (msg_valid) begin
               if (cnt_q == CNT_W'(K-1)) begin
                  state_d = EMIT;
                  cnt_d   = '0;
                  cw_d    = cw_load;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         EMIT: begin
            cw_valid = 1'b1;
            if (cw_ready) begin
               state_d  = COLLECT;
               lfsr_clr = 1'b1;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         cw_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cw_q    <= cw_d;
      end
   end

   assign codeword = cw_q;

endmodule
